// File: rtl/psd_eth_tx_pkg.sv
// Shared types and constants for the PSD Ethernet frame transmitter.
package psd_eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        PAYLOAD,
        PAD
    } tx_state_e;

    localparam logic [47:0] DEFAULT_DST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DEFAULT_SRC_MAC   = 48'h0A35_0000_0001;
    localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

    // Payload + pad words needed to reach the 60-byte minimum frame.
    localparam int MIN_PAYLOAD_WORDS = 6;

    // Turns a big-endian packed word (first wire byte in bits 63:56) into
    // bus order, where the first wire byte travels in bits 7:0.
    function automatic logic [63:0] wire_order(input logic [63:0] be);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = be[63-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/psd_tx_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rd_data_o whenever empty_o is low; a write is accepted while full only if
// a pop happens in the same cycle.
module psd_tx_fifo #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psd_eth_tx.sv
// Packs PSD bins into raw Ethernet frames on a 64-bit AXI-Stream master.
// Stream handshake: a word transfers on a rising edge where tvalid and
// tready are both high; while tvalid is high and tready low the word
// (tdata/tlast) is held unchanged, and the FSM only advances on a transfer.
module psd_eth_tx
    import psd_eth_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC       = DEFAULT_DST_MAC,
    parameter logic [47:0] SRC_MAC       = DEFAULT_SRC_MAC,
    parameter logic [15:0] ETHERTYPE     = DEFAULT_ETHERTYPE,
    parameter int          PAYLOAD_WORDS = 128,
    parameter int          FIFO_DEPTH    = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [61:0] sum_mag_sq,
    input  logic        sum_mag_sq_valid,
    input  logic        psd_done,
    input  logic        tx_enable,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        overflow,
    output logic [14:0] frame_seq,
    output tx_state_e   dbg_state_o
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          CW    = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [AW:0] PW_L  = (AW+1)'(PAYLOAD_WORDS);
    localparam logic [CW-1:0] LAST_PAY = CW'(PAYLOAD_WORDS - 1);
    localparam logic [CW-1:0] LAST_MIN = CW'(MIN_PAYLOAD_WORDS - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] words_q, words_d;
    logic [14:0]   seq_q, seq_d;
    logic          flag_q, flag_d;
    logic          overflow_q;
    logic [AW:0]   wr_abs_q;
    logic [AW:0]   rd_abs_q;

    logic [64:0]   head;
    logic          main_full, main_empty;
    logic [AW:0]   fill;
    logic [AW:0]   last_head;
    logic [AW:0]   last_cnt;
    logic [AW:0]   last_dist;
    logic          idx_full, idx_empty;
    logic          pop, main_pop, wr_ok, drop, end_pay;
    logic [63:0]   tdata;
    logic          tvalid, tlast;

    // A full FIFO still takes a bin when the head is popped in that cycle.
    assign main_pop = pop && !main_empty;
    assign wr_ok    = sum_mag_sq_valid && (!main_full || main_pop);
    assign drop     = sum_mag_sq_valid && main_full && !main_pop;

    psd_tx_fifo #(.WIDTH(65), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_ok),
        .wr_data_i ({psd_done, 2'b00, sum_mag_sq}),
        .rd_en_i   (main_pop),
        .rd_data_o (head),
        .full_o    (main_full),
        .empty_o   (main_empty),
        .count_o   (fill)
    );

    // Absolute write positions of psd_done entries, oldest first. Its fill
    // count is the last-counter, and its head tells how far into the data
    // FIFO the first psd_done entry sits, which decides the HDR1 flag.
    psd_tx_fifo #(.WIDTH(AW + 1), .DEPTH(FIFO_DEPTH)) u_last_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_ok && psd_done),
        .wr_data_i (wr_abs_q),
        .rd_en_i   (main_pop && head[64]),
        .rd_data_o (last_head),
        .full_o    (idx_full),
        .empty_o   (idx_empty),
        .count_o   (last_cnt)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, idx_full, idx_empty};

    assign last_dist = last_head - rd_abs_q;

    // Next-state and stream outputs; all outputs are zero in IDLE.
    always_comb begin
        state_d = state_q;
        words_d = words_q;
        seq_d   = seq_q;
        flag_d  = flag_q;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tdata   = '0;
        pop     = 1'b0;
        end_pay = head[64] || (words_q == LAST_PAY);
        case (state_q)
            IDLE: begin
                if (tx_enable && (fill >= PW_L || last_cnt != '0)) begin
                    state_d = HDR0;
                end
            end
            HDR0: begin
                tvalid = 1'b1;
                tdata  = wire_order({DST_MAC, SRC_MAC[47:32]});
                if (m_axis_tready) begin
                    state_d = HDR1;
                    // Frame entries are all present now, so the flag is final.
                    flag_d  = (last_cnt != '0) && (last_dist < PW_L);
                end
            end
            HDR1: begin
                tvalid = 1'b1;
                tdata  = wire_order({SRC_MAC[31:0], ETHERTYPE, flag_q, seq_q});
                if (m_axis_tready) begin
                    state_d = PAYLOAD;
                    words_d = '0;
                end
            end
            PAYLOAD: begin
                tvalid = 1'b1;
                tdata  = head[63:0];
                tlast  = end_pay && (words_q >= LAST_MIN);
                if (m_axis_tready) begin
                    pop     = 1'b1;
                    words_d = words_q + 1'b1;
                    if (tlast) begin
                        state_d = IDLE;
                        seq_d   = seq_q + 1'b1;
                    end else if (end_pay) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                tvalid = 1'b1;
                tlast  = (words_q == LAST_MIN);
                if (m_axis_tready) begin
                    words_d = words_q + 1'b1;
                    if (tlast) begin
                        state_d = IDLE;
                        seq_d   = seq_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            words_q    <= '0;
            seq_q      <= '0;
            flag_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_abs_q   <= '0;
            rd_abs_q   <= '0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            seq_q      <= seq_d;
            flag_q     <= flag_d;
            overflow_q <= overflow_q | drop;
            if (wr_ok) begin
                wr_abs_q <= wr_abs_q + 1'b1;
            end
            if (main_pop) begin
                rd_abs_q <= rd_abs_q + 1'b1;
            end
        end
    end

    assign m_axis_tdata  = tdata;
    assign m_axis_tkeep  = 8'hFF;
    assign m_axis_tlast  = tlast;
    assign m_axis_tuser  = 1'b0;
    assign m_axis_tvalid = tvalid;
    assign overflow      = overflow_q;
    assign frame_seq     = seq_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_psd_eth_tx.sv
// Self-checking bench for psd_eth_tx: a frame model fills an expected-word
// queue as bins are driven; a monitor pops it on every stream transfer.
module tb_psd_eth_tx;
    import psd_eth_tx_pkg::*;

    localparam int          PW     = 128;
    localparam logic [47:0] TB_DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] TB_SRC = 48'h0A35_0000_0001;
    localparam logic [15:0] TB_ETH = 16'h88B5;

    logic        clk;
    logic        reset;
    logic [61:0] sum_mag_sq;
    logic        sum_mag_sq_valid;
    logic        psd_done;
    logic        tx_enable;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow;
    logic [14:0] frame_seq;
    tx_state_e   dbg_state;

    psd_eth_tx dut (
        .clk              (clk),
        .reset            (reset),
        .sum_mag_sq       (sum_mag_sq),
        .sum_mag_sq_valid (sum_mag_sq_valid),
        .psd_done         (psd_done),
        .tx_enable        (tx_enable),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .overflow         (overflow),
        .frame_seq        (frame_seq),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];      // {tlast, tdata}
    logic [61:0] chunk_v[$];    // bins of the frame being assembled
    logic [14:0] exp_seq;
    int          vectors;
    int          miscompares;
    bit          mon_en;
    bit          rand_ready;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Builds one complete expected frame from the collected bins.
    task automatic model_frame(input logic flag);
        logic [7:0]  b [16];
        logic [63:0] w;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        int n;
        int total;
        dst = TB_DST;
        src = TB_SRC;
        et  = TB_ETH;
        for (int k = 0; k < 6; k++) begin
            b[k]     = dst[47-8*k -: 8];
            b[6 + k] = src[47-8*k -: 8];
        end
        b[12] = et[15:8];
        b[13] = et[7:0];
        b[14] = {flag, exp_seq[14:8]};
        b[15] = exp_seq[7:0];
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 8; k++) w[8*k +: 8] = b[8*h + k];
            exp_q.push_back({1'b0, w});
        end
        n     = chunk_v.size();
        total = (n < 6) ? 6 : n;
        for (int j = 0; j < total; j++) begin
            w = (j < n) ? {2'b00, chunk_v[j]} : 64'h0;
            exp_q.push_back({(j == total - 1), w});
        end
        chunk_v.delete();
        exp_seq = exp_seq + 15'd1;
    endtask

    task automatic model_bin(input logic [61:0] v, input logic d);
        chunk_v.push_back(v);
        if (d || chunk_v.size() == PW) model_frame(d);
    endtask

    // ---------------- driver tasks ----------------
    task automatic ready_driver();
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic drive_bins(input int n, input int done_at, input bit rnd);
        logic [61:0] v;
        for (int i = 1; i <= n; i++) begin
            v = rnd ? {30'($urandom), 32'($urandom)} : 62'(i);
            sum_mag_sq       = v;
            sum_mag_sq_valid = 1'b1;
            psd_done         = (i == done_at);
            model_bin(v, i == done_at);
            step();
        end
        sum_mag_sq_valid = 1'b0;
        psd_done         = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        step();
    endtask

    // ---------------- monitor (scoreboard consumer) ----------------
    task automatic monitor();
        logic [73:0] got;
        logic [73:0] want;
        logic [73:0] hold_w;
        logic [64:0] e;
        bit          hold_v;
        hold_v = 1'b0;
        hold_w = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                hold_v = 1'b0;
                continue;
            end
            got = {m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid) begin
                if (hold_v) begin
                    vectors++;
                    if (got !== hold_w) begin
                        miscompares++;
                        $display("FAIL stall_stable: got %h held %h", got, hold_w);
                    end
                end
                if (m_axis_tready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_word: got %h want none", got);
                    end else begin
                        e    = exp_q.pop_front();
                        want = {1'b0, 8'hFF, e};
                        if (got !== want) begin
                            miscompares++;
                            $display("FAIL word: got %h want %h", got, want);
                        end
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_w = got;
                end
            end else begin
                if (hold_v) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL valid_drop: got tvalid 0 want 1 during stall");
                end
                hold_v = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        vectors++;
        if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        vectors++;
        if (m_axis_tdata !== 64'h0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        vectors++;
        if (frame_seq !== 15'd0) begin miscompares++; $display("FAIL reset_seq: got %0d want 0", frame_seq); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        vectors++;
        if ({m_axis_tkeep, m_axis_tuser} !== 9'h1FE) begin
            miscompares++; $display("FAIL keep_user: got %h want 1fe", {m_axis_tkeep, m_axis_tuser});
        end
        vectors++;
        if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        reset = 1'b0;
        step();
    endtask

    task automatic check_after_drain(input string name, input bit ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL %s_drain: got %0d words pending want 0", name, exp_q.size()); end
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL %s_idle: got tvalid %b want 0", name, m_axis_tvalid); end
        vectors++;
        if (frame_seq !== exp_seq) begin miscompares++; $display("FAIL %s_seq: got %0d want %0d", name, frame_seq, exp_seq); end
    endtask

    task automatic test_single_frame();
        bit ok;
        tx_enable = 1'b1;
        drive_bins(10, 10, 1'b0);
        wait_drain(ok);
        check_after_drain("single", ok);
    endtask

    task automatic test_short_pad();
        bit ok;
        drive_bins(2, 2, 1'b0);
        wait_drain(ok);
        check_after_drain("pad", ok);
    endtask

    task automatic test_multi_frame();
        bit ok;
        drive_bins(300, 300, 1'b1);
        wait_drain(ok);
        check_after_drain("multi", ok);
    endtask

    task automatic test_random_ready();
        bit ok;
        rand_ready = 1'b1;
        drive_bins(300, 300, 1'b1);
        wait_drain(ok);
        rand_ready = 1'b0;
        step();
        check_after_drain("randready", ok);
    endtask

    task automatic test_overflow();
        bit ok;
        logic [61:0] v;
        tx_enable = 1'b0;
        for (int i = 1; i <= 520; i++) begin
            if (i == 513) begin
                vectors++;
                if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_at_512: got %b want 0", overflow); end
            end
            if (i == 514) begin
                vectors++;
                if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_at_513: got %b want 1", overflow); end
            end
            v = {30'($urandom), 32'($urandom)};
            sum_mag_sq       = v;
            sum_mag_sq_valid = 1'b1;
            psd_done         = 1'b0;
            if (i <= 512) model_bin(v, 1'b0);
            step();
        end
        sum_mag_sq_valid = 1'b0;
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL ovf_no_start: got tvalid %b want 0", m_axis_tvalid); end
        tx_enable = 1'b1;
        wait_drain(ok);
        check_after_drain("ovf", ok);
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit seen_valid;
        int hs;
        tx_enable = 1'b1;
        drive_bins(10, 10, 1'b0);
        hs = 0;
        for (int c = 0; c < 200 && hs < 4; c++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) hs++;
        end
        vectors++;
        if (hs != 4) begin miscompares++; $display("FAIL midreset_reach: got %0d transfers want 4", hs); end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        step();
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL midreset_tvalid: got %b want 0", m_axis_tvalid); end
        vectors++;
        if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL midreset_tlast: got %b want 0", m_axis_tlast); end
        vectors++;
        if (frame_seq !== 15'd0) begin miscompares++; $display("FAIL midreset_seq: got %0d want 0", frame_seq); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL midreset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        exp_q.delete();
        chunk_v.delete();
        exp_seq = 15'd0;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (m_axis_tvalid) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid) begin miscompares++; $display("FAIL midreset_empty: got frame start want none"); end
        mon_en = 1'b1;
        drive_bins(3, 3, 1'b0);
        wait_drain(ok);
        check_after_drain("postreset", ok);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors          = 0;
        miscompares      = 0;
        exp_seq          = 15'd0;
        mon_en           = 1'b0;
        rand_ready       = 1'b0;
        reset            = 1'b1;
        sum_mag_sq       = '0;
        sum_mag_sq_valid = 1'b0;
        psd_done         = 1'b0;
        tx_enable        = 1'b0;
        m_axis_tready    = 1'b1;
        fork
            ready_driver();
            monitor();
        join_none
        test_reset();
        mon_en = 1'b1;
        test_single_frame();
        test_short_pad();
        test_multi_frame();
        test_random_ready();
        test_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psd_eth_tx.md
PSD_ETH_TX -- requirements
Module: psd_eth_tx

Interface
REQ-001 SHALL have parameter DST_MAC, default 48'hFFFF_FFFF_FFFF, destination MAC of emitted frames.
REQ-002 SHALL have parameter SRC_MAC, default 48'h0A35_0000_0001, source MAC.
REQ-003 SHALL have parameter ETHERTYPE, default 16'h88B5, frame EtherType.
REQ-004 SHALL have parameter PAYLOAD_WORDS, default 128, max payload words per frame (range 6..FIFO_DEPTH).
REQ-005 SHALL have parameter FIFO_DEPTH, default 512, buffer entries (power of 2).
REQ-006 SHALL use a single clock and a synchronous, active-high reset: clk  in  1  clock for all logic.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 sum_mag_sq  in  62  PSD bin value from welch_psd.
REQ-009 sum_mag_sq_valid  in  1  bin strobe; no backpressure toward source.
REQ-010 psd_done  in  1  qualifies the current valid bin as last of a PSD.
REQ-011 tx_enable  in  1  permits new frame starts.
REQ-012 m_axis_tdata  out  64  frame data; wire byte 0 in tdata[7:0].
REQ-013 m_axis_tkeep  out  8  constant 8'hFF.
REQ-014 m_axis_tlast  out  1  last word of frame.
REQ-015 m_axis_tuser  out  1  constant 0.
REQ-016 m_axis_tvalid  out  1  word valid.
REQ-017 m_axis_tready  in  1  sink ready.
REQ-018 overflow  out  1  sticky: a bin was dropped.
REQ-019 frame_seq  out  15  sequence number of the next frame to be sent.

Function
REQ-020 Each valid bin SHALL be written to the FIFO as {psd_done, 2'b00, sum_mag_sq} (65 bits) in the same cycle.
REQ-021 On a write while the FIFO is full, the bin SHALL be dropped and overflow set; the FIFO is unchanged.
REQ-022 A counter SHALL track FIFO entries with bit 64 set (inc on write, dec on pop; simultaneous -> unchanged).
REQ-023 FSM states SHALL be IDLE, HDR0, HDR1, PAYLOAD, PAD.
REQ-024 IDLE->HDR0 when tx_enable=1 and (fill >= PAYLOAD_WORDS or last-counter > 0).
REQ-025 HDR0 word: DST_MAC (bytes 0-5), SRC_MAC[47:32] (bytes 6-7), network byte order.
REQ-026 HDR1 word: SRC_MAC[31:0] (bytes 8-11), ETHERTYPE (12-13), {last_of_frame, frame_seq} (14-15); last_of_frame=1 iff the frame will carry a psd_done entry within its payload.
REQ-027 PAYLOAD SHALL pop one entry per accepted word, tdata=entry[63:0] (LS byte on wire first).
REQ-028 PAYLOAD ends after PAYLOAD_WORDS words or after popping an entry with bit 64 set, whichever first.
REQ-029 If fewer than 6 payload words were sent, PAD SHALL emit all-zero words until payload+pad = 6 (60-byte minimum frame).
REQ-030 m_axis_tlast SHALL be 1 on the final PAYLOAD or PAD word only; next state IDLE; frame_seq increments (wraps 32767->0) on that handshake.
REQ-031 tvalid SHALL be 1 in every non-IDLE state; tdata/tlast SHALL remain stable while tvalid=1 and tready=0; state advances only on tvalid&&tready.
REQ-032 FIFO write and pop in the same cycle SHALL both occur, fill unchanged, including when full.
REQ-033 tx_enable deassertion SHALL not abort a frame in progress.

Reset
REQ-034 Reset SHALL empty the FIFO, clear the last-counter and overflow, set frame_seq=0, state IDLE, tvalid=0, tlast=0, tdata=0, on the next clk edge.
REQ-035 Reset mid-frame SHALL truncate the frame without tlast; no partial words after reset.

Structure
REQ-036 Package psd_eth_tx_pkg SHALL hold the state enum, default MAC/EtherType constants, and MIN_PAYLOAD_WORDS=6.
REQ-037 Sub-module psd_tx_fifo SHALL be a synchronous first-word-fall-through FIFO (65 bits x FIFO_DEPTH) with full, empty, and fill count.

Verification
REQ-038 10 bins 1..10, last with psd_done, tready=1 -> one frame of 12 words, seq 0, HDR1 byte 14 bit7=1, payload 1..10, tlast on word 12.
REQ-039 300 bins with psd_done on bin 300, PAYLOAD_WORDS=128 -> frames of 130,130,46 words; seq 0,1,2; last_of_frame flag only on frame 2.
REQ-040 2 bins with psd_done -> 8-word frame: 2 payload, 4 zero pad words, tlast on word 8.
REQ-041 Random tready (50%) on scenario REQ-039 -> identical word sequence; tdata stable during stalls.
REQ-042 tx_enable=0, 520 bins -> 512 stored, overflow=1 from bin 513; then tx_enable=1 -> four 130-word frames.
REQ-043 Reset asserted during payload word 3 -> tvalid=0 next cycle, frame_seq=0, overflow=0, FIFO empty.
